seq_alu_core: RTL and testbench
===============================

Name: seq_alu_core

Overview:
Parametrised sequential ALU core, the successor to the 8-bit pin-level ALU wrapper. It accepts an operand pair and opcode through a valid/ready handshake. Single-cycle logic/arithmetic ops complete in one cycle; MUL and DIV run as iterative WIDTH-cycle shift-add and restoring-divide engines. Results are held behind an output valid/ready handshake. The top-level pin wrapper instantiates it with WIDTH=8 and maps ui_in/uio_in/uo_out onto these ports.

Parameters:
WIDTH, 8, operand width in bits (>=4, power of two)
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  operand/opcode valid
in_ready  out  1  core can accept a request
op  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL, 8 DIV; 9-15 illegal
a  in  WIDTH  operand A
b  in  WIDTH  operand B
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
res_lo  out  WIDTH  result / MUL low half / DIV quotient
res_hi  out  WIDTH  MUL high half / DIV remainder; 0 for other ops
flag_z  out  1  zero: res_lo==0 (MUL/DIV: res_lo==0 and res_hi==0)
flag_c  out  1  carry/borrow/shifted-out bit
flag_v  out  1  signed overflow (ADD/SUB only, else 0)
flag_err  out  1  illegal opcode or divide by zero

Behaviour:
- States: IDLE, BUSY, DONE. Reset (async, any state, including mid-MUL/DIV) -> IDLE. All outputs 0 except in_ready=1. Iteration counter and working registers cleared.
- in_ready = (state==IDLE) | (state==DONE & out_ready). out_valid = (state==DONE).
- Acceptance edge k: in_valid & in_ready. a, b and op are captured. Inputs are ignored at all other times.
- ADD/SUB/AND/OR/XOR/SHL/SHR, illegal op, DIV with b==0: the result is registered at edge k. State -> DONE, so out_valid is high after edge k (1-cycle latency).
- MUL/DIV with b!=0: state -> BUSY at edge k, counter=0. One iteration per edge. At the edge where the counter reaches WIDTH, the result is registered and state -> DONE. out_valid is high after edge k+WIDTH.
- DONE holds all results and flags stable until out_ready=1. With out_ready=1 and in_valid=1 on the same edge, the new request is accepted (back-to-back) and the next state follows the rules above. With out_ready=1 and in_valid=0, state -> IDLE and out_valid drops.
- ADD: res_lo=(a+b) mod 2^WIDTH; flag_c=carry out; flag_v=signed overflow.
- SUB: res_lo=(a-b) mod 2^WIDTH; flag_c=1 iff a<b unsigned (borrow); flag_v=signed overflow.
- AND/OR/XOR: flag_c=0.
- SHL/SHR: logical shift by amount s=b[CNT_W-2:0]; upper bits of b ignored. flag_c = last bit shifted out; flag_c=0 when s=0.
- MUL: unsigned; {res_hi,res_lo}=a*b (2*WIDTH bits); flag_c=(res_hi!=0).
- DIV: unsigned restoring division; res_lo=a/b, res_hi=a%b, flag_c=0.
- DIV with b==0: res_lo=all ones, res_hi=a, flag_err=1, flag_z=0, 1-cycle latency.
- Illegal op: res_lo=res_hi=0, flag_err=1, flag_z=1, flag_c=flag_v=0.
- flag_v=0 and flag_err=0 unless specified above.
- res_hi=0 for all ops except MUL/DIV.
- While BUSY: in_ready=0, out_valid=0, and in_valid is ignored.

Test Plan:
- Reset mid-operation: accept MUL 200*3, assert rst at cycle 4 -> out_valid=0 and in_ready=1 immediately (asynchronous); a subsequent ADD completes normally.
- ADD/SUB flags, WIDTH=8: ADD 0x7F+0x01 -> res_lo=0x80, v=1, c=0. ADD 0xFF+0x01 -> 0x00, z=1, c=1. SUB 0x10-0x20 -> 0xF0, c=1.
- MUL 0xFF*0xFF -> out_valid exactly 8 cycles after acceptance, res_hi=0xFE, res_lo=0x01, c=1, in_ready=0 throughout BUSY.
- DIV 100/7 -> res_lo=14, res_hi=2, latency 8. DIV 5/0 -> res_lo=0xFF, res_hi=5, err=1, latency 1.
- Backpressure and back-to-back: hold out_ready=0 for 5 cycles after XOR 0xAA^0x0F -> 0xA5 stays stable. Raising out_ready with in_valid=1 (SHL 0x81 by 1) -> accepted on the same edge; next result 0x02, c=1.
- Illegal op 12 -> res 0, err=1, z=1. Re-run the MUL and ADD cases at WIDTH=16 with 0xFFFF*0xFFFF -> {0xFFFE,0x0001}, latency 16.

Source files
------------

// File: rtl/seq_alu_core_if.sv
// Request/response bus of the sequential ALU core: operand/opcode handshake
// in, result/flags handshake out.
interface seq_alu_core_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] res_lo;
   logic [WIDTH-1:0] res_hi;
   logic             flag_z;
   logic             flag_c;
   logic             flag_v;
   logic             flag_err;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, res_lo, res_hi, flag_z, flag_c, flag_v, flag_err
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, res_lo, res_hi, flag_z, flag_c, flag_v, flag_err
   );
endinterface

// File: rtl/seq_alu_core.sv
// Sequential ALU core: single-cycle logic/arithmetic ops, WIDTH-iteration
// shift-add multiply and restoring divide, results held until consumed.
module seq_alu_core #(
   parameter int WIDTH = 8
) (
   input logic           clk,
   input logic           rst,
   seq_alu_core_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam int SH_W  = CNT_W - 1;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_SHL = 4'd5;
   localparam logic [3:0] OP_SHR = 4'd6;
   localparam logic [3:0] OP_MUL = 4'd7;
   localparam logic [3:0] OP_DIV = 4'd8;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   state_t           state_nx;

   logic             accept;
   logic             start_iter;
   logic             last_iter;

   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] work_hi;
   logic [WIDTH-1:0] work_lo;
   logic [WIDTH-1:0] opnd;
   logic             is_div;

   logic [WIDTH-1:0] res_lo_q;
   logic [WIDTH-1:0] res_hi_q;
   logic             z_q;
   logic             c_q;
   logic             v_q;
   logic             err_q;

   logic [SH_W-1:0]  sh_amt;
   logic [WIDTH:0]   add_x;
   logic [WIDTH:0]   sub_x;
   logic [WIDTH:0]   shl_x;
   logic [WIDTH:0]   shr_x;
   logic [WIDTH-1:0] sc_lo;
   logic [WIDTH-1:0] sc_hi;
   logic             sc_z;
   logic             sc_c;
   logic             sc_v;
   logic             sc_err;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_diff;
   logic [WIDTH-1:0] it_hi;
   logic [WIDTH-1:0] it_lo;

   assign bus.in_ready  = (state == IDLE) | ((state == DONE) & bus.out_ready);
   assign bus.out_valid = (state == DONE);
   assign bus.res_lo    = res_lo_q;
   assign bus.res_hi    = res_hi_q;
   assign bus.flag_z    = z_q;
   assign bus.flag_c    = c_q;
   assign bus.flag_v    = v_q;
   assign bus.flag_err  = err_q;

   assign accept     = bus.in_valid & bus.in_ready;
   assign start_iter = (bus.op == OP_MUL) | ((bus.op == OP_DIV) & (bus.b != '0));
   assign last_iter  = (cnt == CNT_W'(WIDTH - 1));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state: accepted requests go to BUSY (MUL/DIV) or straight to DONE
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (accept) state_nx = start_iter ? BUSY : DONE;
         BUSY: if (last_iter) state_nx = DONE;
         DONE: begin
            if (accept)             state_nx = start_iter ? BUSY : DONE;
            else if (bus.out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Single-cycle result and flags computed straight from the request inputs
   always_comb begin
      sh_amt = bus.b[SH_W-1:0];
      add_x  = {1'b0, bus.a} + {1'b0, bus.b};
      sub_x  = {1'b0, bus.a} - {1'b0, bus.b};
      shl_x  = {1'b0, bus.a} << sh_amt;
      shr_x  = {bus.a, 1'b0} >> sh_amt;
      sc_lo  = '0;
      sc_hi  = '0;
      sc_c   = 1'b0;
      sc_v   = 1'b0;
      sc_err = 1'b0;
      case (bus.op)
         OP_ADD: begin
            sc_lo = add_x[WIDTH-1:0];
            sc_c  = add_x[WIDTH];
            sc_v  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) & (add_x[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_SUB: begin
            sc_lo = sub_x[WIDTH-1:0];
            sc_c  = sub_x[WIDTH];
            sc_v  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) & (sub_x[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_AND: sc_lo = bus.a & bus.b;
         OP_OR:  sc_lo = bus.a | bus.b;
         OP_XOR: sc_lo = bus.a ^ bus.b;
         // The bit landing just outside the result window is the last one shifted out
         OP_SHL: begin
            sc_lo = shl_x[WIDTH-1:0];
            sc_c  = shl_x[WIDTH];
         end
         OP_SHR: begin
            sc_lo = shr_x[WIDTH:1];
            sc_c  = shr_x[0];
         end
         OP_MUL: sc_lo = '0;
         // Only registered from here when the divisor is zero
         OP_DIV: begin
            sc_lo  = '1;
            sc_hi  = bus.a;
            sc_err = 1'b1;
         end
         default: sc_err = 1'b1;
      endcase
      sc_z = (sc_lo == '0) & (sc_hi == '0);
   end

   // One MUL or DIV step on the shared {work_hi, work_lo} register pair
   always_comb begin
      mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : '0);
      div_shift = {work_hi, work_lo[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd};
      it_hi     = mul_sum[WIDTH:1];
      it_lo     = {mul_sum[0], work_lo[WIDTH-1:1]};
      if (is_div) begin
         if (!div_diff[WIDTH]) begin
            it_hi = div_diff[WIDTH-1:0];
            it_lo = {work_lo[WIDTH-2:0], 1'b1};
         end else begin
            it_hi = div_shift[WIDTH-1:0];
            it_lo = {work_lo[WIDTH-2:0], 1'b0};
         end
      end
   end

   // Operand capture, iteration and result/flag registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         work_hi  <= '0;
         work_lo  <= '0;
         opnd     <= '0;
         is_div   <= 1'b0;
         res_lo_q <= '0;
         res_hi_q <= '0;
         z_q      <= 1'b0;
         c_q      <= 1'b0;
         v_q      <= 1'b0;
         err_q    <= 1'b0;
      end else if (accept) begin
         if (start_iter) begin
            // MUL shifts the multiplier b out of work_lo; DIV shifts the dividend a
            cnt     <= '0;
            work_hi <= '0;
            work_lo <= (bus.op == OP_MUL) ? bus.b : bus.a;
            opnd    <= (bus.op == OP_MUL) ? bus.a : bus.b;
            is_div  <= (bus.op == OP_DIV);
         end else begin
            res_lo_q <= sc_lo;
            res_hi_q <= sc_hi;
            z_q      <= sc_z;
            c_q      <= sc_c;
            v_q      <= sc_v;
            err_q    <= sc_err;
         end
      end else if (state == BUSY) begin
         cnt     <= cnt + 1'b1;
         work_hi <= it_hi;
         work_lo <= it_lo;
         if (last_iter) begin
            // Product {hi,lo} and {remainder,quotient} share the same layout
            res_lo_q <= it_lo;
            res_hi_q <= it_hi;
            z_q      <= (it_lo == '0) & (it_hi == '0);
            c_q      <= ~is_div & (it_hi != '0);
            v_q      <= 1'b0;
            err_q    <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_seq_alu_core.sv
// Directed bench for seq_alu_core at WIDTH=8 and WIDTH=16.
module tb_seq_alu_core;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   seq_alu_core_if #(.WIDTH(8))  bus8 ();
   seq_alu_core_if #(.WIDTH(16)) bus16 ();

   seq_alu_core #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
   seq_alu_core #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [7:0]  a;
      logic [7:0]  b;
      int          edges;
      logic [19:0] exp;
   } vec8_t;

   task automatic send8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      bus8.op = op; bus8.a = a; bus8.b = b; bus8.in_valid = 1'b1;
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
   endtask

   task automatic send16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      bus16.op = op; bus16.a = a; bus16.b = b; bus16.in_valid = 1'b1;
      @(posedge clk); #1;
      bus16.in_valid = 1'b0;
   endtask

   task automatic wait8(output int edges, output bit rdy_busy);
      edges = 0; rdy_busy = 1'b0;
      while (!bus8.out_valid && edges < 40) begin
         if (bus8.in_ready) rdy_busy = 1'b1;
         @(posedge clk); #1;
         edges++;
      end
      if (!bus8.out_valid) edges = -1;
   endtask

   task automatic wait16(output int edges, output bit rdy_busy);
      edges = 0; rdy_busy = 1'b0;
      while (!bus16.out_valid && edges < 40) begin
         if (bus16.in_ready) rdy_busy = 1'b1;
         @(posedge clk); #1;
         edges++;
      end
      if (!bus16.out_valid) edges = -1;
   endtask

   task automatic consume8();
      bus8.out_ready = 1'b1;
      @(posedge clk); #1;
      bus8.out_ready = 1'b0;
   endtask

   task automatic consume16();
      bus16.out_ready = 1'b1;
      @(posedge clk); #1;
      bus16.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if ({bus8.in_ready, bus8.out_valid, bus8.res_hi, bus8.res_lo, bus8.flag_z,
           bus8.flag_c, bus8.flag_v, bus8.flag_err} !== {2'b10, 16'h0000, 4'h0}) begin
         n_fail++;
         $display("FAIL reset_w8: got %b expected %b", {bus8.in_ready, bus8.out_valid,
                  bus8.res_hi, bus8.res_lo, bus8.flag_z, bus8.flag_c, bus8.flag_v,
                  bus8.flag_err}, {2'b10, 16'h0000, 4'h0});
      end
      n_checks++;
      if ({bus16.in_ready, bus16.out_valid, bus16.res_hi, bus16.res_lo, bus16.flag_z,
           bus16.flag_c, bus16.flag_v, bus16.flag_err} !== {2'b10, 32'h0, 4'h0}) begin
         n_fail++;
         $display("FAIL reset_w16: got %b expected %b", {bus16.in_ready, bus16.out_valid,
                  bus16.res_hi, bus16.res_lo, bus16.flag_z, bus16.flag_c, bus16.flag_v,
                  bus16.flag_err}, {2'b10, 32'h0, 4'h0});
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset_mid();
      int edges;
      bit rb;
      send8(4'd7, 8'd200, 8'd3);
      n_checks++;
      if ({bus8.in_ready, bus8.out_valid} !== 2'b00) begin
         n_fail++;
         $display("FAIL busy_handshake: got %b expected 00", {bus8.in_ready, bus8.out_valid});
      end
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({bus8.in_ready, bus8.out_valid, bus8.res_lo} !== {2'b10, 8'h00}) begin
         n_fail++;
         $display("FAIL async_reset_mid_mul: got %h expected %h",
                  {bus8.in_ready, bus8.out_valid, bus8.res_lo}, {2'b10, 8'h00});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      send8(4'd0, 8'd3, 8'd4);
      wait8(edges, rb);
      n_checks++;
      if ({edges, bus8.res_hi, bus8.res_lo, bus8.flag_z, bus8.flag_c, bus8.flag_v, bus8.flag_err}
          !== {32'd0, 8'h00, 8'h07, 4'h0}) begin
         n_fail++;
         $display("FAIL add_after_reset: got lat=%0d res=%h expected lat=0 res=0007 flags=0",
                  edges, {bus8.res_hi, bus8.res_lo});
      end
      consume8();
   endtask

   task automatic test_single_cycle();
      vec8_t tbl [11];
      int edges;
      bit rb;
      tbl = '{'{4'd0, 8'h7F, 8'h01, 0, 20'h00802},
              '{4'd0, 8'hFF, 8'h01, 0, 20'h0000C},
              '{4'd1, 8'h10, 8'h20, 0, 20'h00F04},
              '{4'd1, 8'h80, 8'h01, 0, 20'h007F2},
              '{4'd2, 8'hF0, 8'h3C, 0, 20'h00300},
              '{4'd3, 8'hF0, 8'h0F, 0, 20'h00FF0},
              '{4'd4, 8'h5A, 8'h5A, 0, 20'h00008},
              '{4'd5, 8'h81, 8'h08, 0, 20'h00810},
              '{4'd5, 8'h03, 8'h07, 0, 20'h00804},
              '{4'd6, 8'h81, 8'h01, 0, 20'h00404},
              '{4'd6, 8'hC0, 8'h0F, 0, 20'h00014}};
      for (int i = 0; i < 11; i++) begin
         send8(tbl[i].op, tbl[i].a, tbl[i].b);
         wait8(edges, rb);
         n_checks++;
         if (edges !== tbl[i].edges || {bus8.res_hi, bus8.res_lo, bus8.flag_z, bus8.flag_c,
             bus8.flag_v, bus8.flag_err} !== tbl[i].exp) begin
            n_fail++;
            $display("FAIL single_cycle[%0d] op=%0d: got lat=%0d %h expected lat=%0d %h", i,
                     tbl[i].op, edges, {bus8.res_hi, bus8.res_lo, bus8.flag_z, bus8.flag_c,
                     bus8.flag_v, bus8.flag_err}, tbl[i].edges, tbl[i].exp);
         end
         consume8();
      end
   endtask

   task automatic test_mul();
      int edges;
      bit rb;
      send8(4'd7, 8'hFF, 8'hFF);
      bus8.op = 4'd0; bus8.a = 8'h01; bus8.b = 8'h01; bus8.in_valid = 1'b1;
      wait8(edges, rb);
      bus8.in_valid = 1'b0;
      n_checks++;
      if (edges !== 8 || rb !== 1'b0) begin
         n_fail++;
         $display("FAIL mul_latency: got lat=%0d ready_in_busy=%0d expected lat=8 ready_in_busy=0",
                  edges, rb);
      end
      n_checks++;
      if ({bus8.res_hi, bus8.res_lo, bus8.flag_z, bus8.flag_c, bus8.flag_v, bus8.flag_err}
          !== 20'hFE014) begin
         n_fail++;
         $display("FAIL mul_ff_ff: got %h expected fe014", {bus8.res_hi, bus8.res_lo,
                  bus8.flag_z, bus8.flag_c, bus8.flag_v, bus8.flag_err});
      end
      consume8();
   endtask

   task automatic test_div();
      vec8_t tbl [4];
      int edges;
      bit rb;
      tbl = '{'{4'd8, 8'd100, 8'd7,  8, 20'h020E0},
              '{4'd8, 8'd5,   8'd0,  0, 20'h05FF1},
              '{4'd8, 8'd3,   8'd10, 8, 20'h03000},
              '{4'd8, 8'hFF,  8'h01, 8, 20'h00FF0}};
      for (int i = 0; i < 4; i++) begin
         send8(tbl[i].op, tbl[i].a, tbl[i].b);
         wait8(edges, rb);
         n_checks++;
         if (edges !== tbl[i].edges || {bus8.res_hi, bus8.res_lo, bus8.flag_z, bus8.flag_c,
             bus8.flag_v, bus8.flag_err} !== tbl[i].exp) begin
            n_fail++;
            $display("FAIL div[%0d] %0d/%0d: got lat=%0d %h expected lat=%0d %h", i, tbl[i].a,
                     tbl[i].b, edges, {bus8.res_hi, bus8.res_lo, bus8.flag_z, bus8.flag_c,
                     bus8.flag_v, bus8.flag_err}, tbl[i].edges, tbl[i].exp);
         end
         consume8();
      end
   endtask

   task automatic test_illegal();
      int edges;
      bit rb;
      send8(4'd12, 8'h12, 8'h34);
      wait8(edges, rb);
      n_checks++;
      if (edges !== 0 || {bus8.res_hi, bus8.res_lo, bus8.flag_z, bus8.flag_c, bus8.flag_v,
          bus8.flag_err} !== 20'h00009) begin
         n_fail++;
         $display("FAIL illegal_op12: got lat=%0d %h expected lat=0 00009", edges,
                  {bus8.res_hi, bus8.res_lo, bus8.flag_z, bus8.flag_c, bus8.flag_v, bus8.flag_err});
      end
      consume8();
      n_checks++;
      if ({bus8.in_ready, bus8.out_valid} !== 2'b10) begin
         n_fail++;
         $display("FAIL drain_to_idle: got %b expected 10", {bus8.in_ready, bus8.out_valid});
      end
   endtask

   task automatic test_back_to_back();
      int edges;
      int unstable;
      bit rb;
      send8(4'd4, 8'hAA, 8'h0F);
      wait8(edges, rb);
      unstable = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (!bus8.out_valid || {bus8.res_hi, bus8.res_lo, bus8.flag_z, bus8.flag_c,
             bus8.flag_v, bus8.flag_err} !== 20'h00A50) unstable++;
      end
      n_checks++;
      if (edges !== 0 || unstable !== 0) begin
         n_fail++;
         $display("FAIL xor_hold: got lat=%0d unstable_cycles=%0d expected lat=0 unstable_cycles=0",
                  edges, unstable);
      end
      bus8.out_ready = 1'b1;
      bus8.op = 4'd5; bus8.a = 8'h81; bus8.b = 8'h01; bus8.in_valid = 1'b1;
      #1;
      n_checks++;
      if (bus8.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_in_ready: got %b expected 1", bus8.in_ready);
      end
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      bus8.out_ready = 1'b0;
      n_checks++;
      if ({bus8.out_valid, bus8.res_hi, bus8.res_lo, bus8.flag_z, bus8.flag_c, bus8.flag_v,
          bus8.flag_err} !== {1'b1, 20'h00024}) begin
         n_fail++;
         $display("FAIL b2b_shl: got %h expected %h", {bus8.out_valid, bus8.res_hi, bus8.res_lo,
                  bus8.flag_z, bus8.flag_c, bus8.flag_v, bus8.flag_err}, {1'b1, 20'h00024});
      end
      consume8();
   endtask

   task automatic test_width16();
      int edges;
      bit rb;
      send16(4'd7, 16'hFFFF, 16'hFFFF);
      wait16(edges, rb);
      n_checks++;
      if (edges !== 16 || rb !== 1'b0 || {bus16.res_hi, bus16.res_lo, bus16.flag_z,
          bus16.flag_c, bus16.flag_v, bus16.flag_err} !== 36'hFFFE_0001_4) begin
         n_fail++;
         $display("FAIL mul16: got lat=%0d rdy=%0d %h expected lat=16 rdy=0 fffe00014", edges, rb,
                  {bus16.res_hi, bus16.res_lo, bus16.flag_z, bus16.flag_c, bus16.flag_v,
                  bus16.flag_err});
      end
      consume16();
      send16(4'd0, 16'h7FFF, 16'h0001);
      wait16(edges, rb);
      n_checks++;
      if (edges !== 0 || {bus16.res_hi, bus16.res_lo, bus16.flag_z, bus16.flag_c,
          bus16.flag_v, bus16.flag_err} !== 36'h0000_8000_2) begin
         n_fail++;
         $display("FAIL add16_ovf: got lat=%0d %h expected lat=0 000080002", edges,
                  {bus16.res_hi, bus16.res_lo, bus16.flag_z, bus16.flag_c, bus16.flag_v,
                  bus16.flag_err});
      end
      consume16();
      send16(4'd0, 16'hFFFF, 16'h0001);
      wait16(edges, rb);
      n_checks++;
      if (edges !== 0 || {bus16.res_hi, bus16.res_lo, bus16.flag_z, bus16.flag_c,
          bus16.flag_v, bus16.flag_err} !== 36'h0000_0000_C) begin
         n_fail++;
         $display("FAIL add16_carry: got lat=%0d %h expected lat=0 00000000c", edges,
                  {bus16.res_hi, bus16.res_lo, bus16.flag_z, bus16.flag_c, bus16.flag_v,
                  bus16.flag_err});
      end
      consume16();
      send16(4'd8, 16'hFFFF, 16'h0100);
      wait16(edges, rb);
      n_checks++;
      if (edges !== 16 || {bus16.res_hi, bus16.res_lo, bus16.flag_z, bus16.flag_c,
          bus16.flag_v, bus16.flag_err} !== 36'h00FF_00FF_0) begin
         n_fail++;
         $display("FAIL div16: got lat=%0d %h expected lat=16 00ff00ff0", edges,
                  {bus16.res_hi, bus16.res_lo, bus16.flag_z, bus16.flag_c, bus16.flag_v,
                  bus16.flag_err});
      end
      consume16();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus8.in_valid  = 1'b0; bus8.out_ready  = 1'b0;
      bus8.op  = 4'd0; bus8.a  = '0; bus8.b  = '0;
      bus16.in_valid = 1'b0; bus16.out_ready = 1'b0;
      bus16.op = 4'd0; bus16.a = '0; bus16.b = '0;
      test_reset();
      test_reset_mid();
      test_single_cycle();
      test_mul();
      test_div();
      test_illegal();
      test_back_to_back();
      test_width16();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
